// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: default reset PC and
// helpers that size the prefetch-queue pointers and occupancy counters.
package if_pkg;

    localparam int unsigned RST_PC_DEFAULT = 0;

    // Index width for a power-of-two circular buffer of the given depth.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Width able to hold any occupancy value from 0 to depth inclusive.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/if_fetch_buf.sv
// In-order prefetch queue: entries are allocated on grant, filled in order by
// memory responses, and popped at the head. A flush empties the queue.
module if_fetch_buf
    import if_pkg::*;
#(
    parameter int PC_W    = 16,
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 4,
    localparam int PW     = ptr_w(DEPTH),
    localparam int CW     = cnt_w(DEPTH)
) (
    input  logic               clk,
    input  logic               nRst,
    input  logic               flush,
    input  logic               alloc,
    input  logic [PC_W-1:0]    allocPc,
    input  logic               fill,
    input  logic [INSTR_W-1:0] fillInstr,
    input  logic               pop,
    output logic               headFilled,
    output logic [PC_W-1:0]    headPc,
    output logic [INSTR_W-1:0] headInstr,
    output logic [CW-1:0]      allocCnt,
    output logic [CW-1:0]      unfilledCnt
);

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               filled;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] headPtr;
    logic [PW-1:0] tailPtr;
    logic [PW-1:0] fillPtr;

    // Alloc targets a free slot and fill targets an allocated-but-unfilled
    // slot, so the two writes never collide on the same index.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            headPtr     <= '0;
            tailPtr     <= '0;
            fillPtr     <= '0;
            allocCnt    <= '0;
            unfilledCnt <= '0;
        end else if (flush) begin
            headPtr     <= '0;
            tailPtr     <= '0;
            fillPtr     <= '0;
            allocCnt    <= '0;
            unfilledCnt <= '0;
        end else begin
            if (alloc) begin
                mem[tailPtr].pc     <= allocPc;
                mem[tailPtr].instr  <= '0;
                mem[tailPtr].filled <= 1'b0;
                tailPtr             <= tailPtr + PW'(1);
            end
            if (fill) begin
                mem[fillPtr].instr  <= fillInstr;
                mem[fillPtr].filled <= 1'b1;
                fillPtr             <= fillPtr + PW'(1);
            end
            if (pop) headPtr <= headPtr + PW'(1);
            allocCnt    <= allocCnt + CW'(alloc) - CW'(pop);
            unfilledCnt <= unfilledCnt + CW'(alloc) - CW'(fill);
        end
    end

    assign headFilled = (allocCnt != '0) && mem[headPtr].filled;
    assign headPc     = mem[headPtr].pc;
    assign headInstr  = mem[headPtr].instr;

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch stage: sequential PC generation, request credit, in-flight
// response discard after redirect. IF_PERF_CNT_EN adds performance counters.
module if_prefetch
    import if_pkg::*;
#(
    parameter int              PC_W    = 16,
    parameter int              INSTR_W = 16,
    parameter int              DEPTH   = 4,
    parameter logic [PC_W-1:0] RST_PC  = PC_W'(RST_PC_DEFAULT)
) (
    input  logic               clk,
    input  logic               nRst,
    input  logic               hlt,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirectPc,
    output logic               imReq,
    output logic [PC_W-1:0]    imAddr,
    input  logic               imGnt,
    input  logic               imRspValid,
    input  logic [INSTR_W-1:0] imRspData,
    output logic               dValid,
    output logic [INSTR_W-1:0] dInstr,
    output logic [PC_W-1:0]    dPc,
    input  logic               dReady,
    output logic [PC_W-1:0]    fetchPc
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]        perfFetched,
    output logic [31:0]        perfDropped,
    output logic [31:0]        perfStall
`endif
);

    localparam int CW = cnt_w(DEPTH);

    logic [CW-1:0] allocCnt;
    logic [CW-1:0] unfilledCnt;
    logic [CW-1:0] dropCnt;
    logic [CW-1:0] dropNext;
    logic [CW:0]   credit;
    logic [CW:0]   pending;
    logic          grant;
    logic          fill;
    logic          pop;
    logic          dropping;

    // Handshakes: a request transfers on imReq&&imGnt, and imReq/imAddr hold
    // until it does; decode transfers on dValid&&dReady, dInstr/dPc holding
    // meanwhile. Both sides may only act on the transfer cycle.
    assign credit   = {1'b0, allocCnt} + {1'b0, dropCnt};
    assign imReq    = !hlt && !redirect && (credit < (CW+1)'(DEPTH));
    assign imAddr   = fetchPc;
    assign grant    = imReq && imGnt;
    assign dropping = imRspValid && (dropCnt != '0);
    assign fill     = imRspValid && (dropCnt == '0) && (unfilledCnt != '0) && !redirect;
    assign pop      = dValid && dReady && !redirect;

    // On redirect every still-unfilled entry becomes a response to discard,
    // less the one arriving this cycle (it is absorbed either way).
    always_comb begin
        pending  = {1'b0, dropCnt} + {1'b0, unfilledCnt};
        dropNext = dropCnt;
        if (redirect) begin
            if (imRspValid && (pending != '0)) pending = pending - (CW+1)'(1);
            dropNext = pending[CW-1:0];
        end else if (dropping) begin
            dropNext = dropCnt - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            fetchPc <= RST_PC;
            dropCnt <= '0;
        end else begin
            dropCnt <= dropNext;
            if (redirect) fetchPc <= redirectPc;
            else if (grant) fetchPc <= fetchPc + PC_W'(1);
        end
    end

    if_fetch_buf #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W),
        .DEPTH   (DEPTH)
    ) u_buf (
        .clk         (clk),
        .nRst        (nRst),
        .flush       (redirect),
        .alloc       (grant),
        .allocPc     (fetchPc),
        .fill        (fill),
        .fillInstr   (imRspData),
        .pop         (pop),
        .headFilled  (dValid),
        .headPc      (dPc),
        .headInstr   (dInstr),
        .allocCnt    (allocCnt),
        .unfilledCnt (unfilledCnt)
    );

`ifdef IF_PERF_CNT_EN
    logic discard;
    assign discard = imRspValid && ((dropCnt != '0) || (redirect && (unfilledCnt != '0)));

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            perfFetched <= '0;
            perfDropped <= '0;
            perfStall   <= '0;
        end else begin
            if (pop) perfFetched <= perfFetched + 32'd1;
            if (discard) perfDropped <= perfDropped + 32'd1;
            if (!imReq && !hlt) perfStall <= perfStall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: queue-based reference model checked every cycle, an
// in-order memory responder with programmable latency, and directed scenarios.
`timescale 1ns/1ps
module tb_if_prefetch;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 16;
    localparam int DEPTH   = 4;
    localparam int EW      = PC_W + INSTR_W + 1;

    // ---------------- clock / reset ----------------
    logic clk  = 1'b0;
    logic nRst = 1'b0;
    always #5 clk = ~clk;

    logic               hlt        = 1'b0;
    logic               redirect   = 1'b0;
    logic [PC_W-1:0]    redirectPc = '0;
    logic               imReq;
    logic [PC_W-1:0]    imAddr;
    logic               imGnt      = 1'b0;
    logic               imRspValid = 1'b0;
    logic [INSTR_W-1:0] imRspData  = '0;
    logic               dValid;
    logic [INSTR_W-1:0] dInstr;
    logic [PC_W-1:0]    dPc;
    logic               dReady     = 1'b0;
    logic [PC_W-1:0]    fetchPc;

    if_prefetch #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .RST_PC(16'h0000)) dut (
        .clk(clk), .nRst(nRst), .hlt(hlt), .redirect(redirect), .redirectPc(redirectPc),
        .imReq(imReq), .imAddr(imAddr), .imGnt(imGnt), .imRspValid(imRspValid),
        .imRspData(imRspData), .dValid(dValid), .dInstr(dInstr), .dPc(dPc),
        .dReady(dReady), .fetchPc(fetchPc)
    );

    // Second instance streams from a reset PC near the top of the address space.
    logic               hlt2        = 1'b0;
    logic               redirect2   = 1'b0;
    logic [PC_W-1:0]    redirectPc2 = '0;
    logic               imReq2;
    logic [PC_W-1:0]    imAddr2;
    logic               imGnt2      = 1'b1;
    logic               imRspValid2 = 1'b0;
    logic [INSTR_W-1:0] imRspData2  = '0;
    logic               dValid2;
    logic [INSTR_W-1:0] dInstr2;
    logic [PC_W-1:0]    dPc2;
    logic               dReady2     = 1'b1;
    logic [PC_W-1:0]    fetchPc2;

    if_prefetch #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .RST_PC(16'hFFFE)) dut2 (
        .clk(clk), .nRst(nRst), .hlt(hlt2), .redirect(redirect2), .redirectPc(redirectPc2),
        .imReq(imReq2), .imAddr(imAddr2), .imGnt(imGnt2), .imRspValid(imRspValid2),
        .imRspData(imRspData2), .dValid(dValid2), .dInstr(dInstr2), .dPc(dPc2),
        .dReady(dReady2), .fetchPc(fetchPc2)
    );

    // ---------------- checking helpers ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [INSTR_W-1:0] mem_data(input logic [PC_W-1:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A5A;
    endfunction

    // ---------------- memory responder (in order, latency >= 1) ----------------
    int              lat = 1;
    int              cyc = 0;
    int              n_gnt = 0;
    int              n_pop = 0;
    logic [PC_W-1:0] mem_addr_q[$];
    int              mem_due_q[$];

    always @(posedge clk) begin
        if (!nRst) begin
            mem_addr_q.delete();
            mem_due_q.delete();
        end else begin
            if (imRspValid && mem_addr_q.size() > 0) begin
                void'(mem_addr_q.pop_front());
                void'(mem_due_q.pop_front());
            end
            if (imReq && imGnt) begin
                mem_addr_q.push_back(imAddr);
                mem_due_q.push_back(cyc + lat);
                n_gnt++;
            end
            if (dValid && dReady) n_pop++;
        end
        cyc++;
        #1;
        if (nRst && mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
            imRspValid = 1'b1;
            imRspData  = mem_data(mem_addr_q[0]);
        end else begin
            imRspValid = 1'b0;
            imRspData  = '0;
        end
    end

    logic            p2 = 1'b0;
    logic [PC_W-1:0] a2 = '0;
    always @(posedge clk) begin
        p2 = nRst && imReq2 && imGnt2;
        a2 = imAddr2;
        #1;
        imRspValid2 = p2;
        imRspData2  = mem_data(a2);
    end

    int              n2 = 0;
    logic [PC_W-1:0] pc2_got [4];
    logic [PC_W-1:0] pc2_want [4];
    logic [INSTR_W-1:0] instr2_first = '0;
    always @(posedge clk) begin
        if (nRst && dValid2 && dReady2 && n2 < 4) begin
            if (n2 == 0) instr2_first = dInstr2;
            pc2_got[n2] = dPc2;
            n2++;
        end
    end

    // ---------------- reference model / scoreboard ----------------
    // Each entry is {filled, pc, instr}; index 0 is the decode head.
    logic [EW-1:0]   exp_q[$];
    logic [PC_W-1:0] m_pc   = '0;
    int              m_drop = 0;

    function automatic bit m_req();
        return !hlt && !redirect && (exp_q.size() + m_drop < DEPTH);
    endfunction

    function automatic bit m_dvalid();
        return (exp_q.size() > 0) && exp_q[0][EW-1];
    endfunction

    always @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            exp_q.delete();
            m_pc   = '0;
            m_drop = 0;
        end else begin
            bit req;
            bit vld;
            int unf;
            bit done;
            req = m_req();
            vld = m_dvalid();
            if (redirect) begin
                unf = 0;
                foreach (exp_q[i]) if (!exp_q[i][EW-1]) unf++;
                unf = unf + m_drop;
                if (imRspValid && unf > 0) unf--;
                m_drop = unf;
                exp_q.delete();
                m_pc = redirectPc;
            end else begin
                if (imRspValid) begin
                    if (m_drop > 0) m_drop--;
                    else begin
                        done = 1'b0;
                        for (int i = 0; i < exp_q.size(); i++) begin
                            if (!done && !exp_q[i][EW-1]) begin
                                exp_q[i][EW-1]        = 1'b1;
                                exp_q[i][INSTR_W-1:0] = imRspData;
                                done = 1'b1;
                            end
                        end
                        if (!done) begin
                            n_cmp++;
                            n_fail++;
                            $display("FAIL rsp_protocol: response with nothing outstanding at %0t", $time);
                        end
                    end
                end
                if (vld && dReady) void'(exp_q.pop_front());
                if (req && imGnt) begin
                    exp_q.push_back({1'b0, m_pc, {INSTR_W{1'b0}}});
                    m_pc = m_pc + 16'd1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (nRst) begin
            check("imReq", imReq, m_req());
            if (m_req()) check("imAddr", imAddr, m_pc);
            check("fetchPc", fetchPc, m_pc);
            check("dValid", dValid, m_dvalid());
            if (m_dvalid()) begin
                check("dPc", dPc, exp_q[0][EW-2:INSTR_W]);
                check("dInstr", dInstr, exp_q[0][INSTR_W-1:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic gnt, input logic rdy, input logic h);
        imGnt  = gnt;
        dReady = rdy;
        hlt    = h;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        nRst     = 1'b0;
        redirect = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        nRst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int g0;
        int waited;
        pc2_want[0] = 16'hFFFE;
        pc2_want[1] = 16'hFFFF;
        pc2_want[2] = 16'h0000;
        pc2_want[3] = 16'h0001;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_dValid", dValid, 0);
        check("rst_dInstr", dInstr, 0);
        check("rst_dPc", dPc, 0);
        check("rst_fetchPc", fetchPc, 0);
        check("rst_fetchPc2", fetchPc2, 32'hFFFE);
        @(posedge clk);
        #1;
        nRst = 1'b1;

        // 1: streaming, latency 1
        lat = 1;
        drive(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("t1_imAddr0", imAddr, 0);
        check("t1_dv_c0", dValid, 0);
        cycle();
        @(negedge clk);
        check("t1_dv_c1", dValid, 0);
        cycle();
        @(negedge clk);
        check("t1_dv_c2", dValid, 1);
        check("t1_dPc_c2", dPc, 0);
        check("t1_dInstr_c2", dInstr, 16'h5A5A);
        repeat (12) cycle();
        @(negedge clk);
        check("t1_dPc_c14", dPc, 16'h000C);

        // 2: decode stalled, credit limit, single-slot release
        do_reset();
        lat = 1;
        g0 = n_gnt;
        drive(1'b1, 1'b0, 1'b0);
        repeat (8) cycle();
        @(negedge clk);
        check("t2_grants4", n_gnt - g0, 4);
        check("t2_imReq_full", imReq, 0);
        check("t2_fetchPc4", fetchPc, 4);
        cycle();
        dReady = 1'b1;
        cycle();
        dReady = 1'b0;
        @(negedge clk);
        check("t2_imReq_freed", imReq, 1);
        check("t2_imAddr4", imAddr, 4);
        repeat (5) cycle();
        @(negedge clk);
        check("t2_grants5", n_gnt - g0, 5);
        check("t2_fetchPc5", fetchPc, 5);

        // 3: redirect with two responses in flight
        do_reset();
        lat = 3;
        drive(1'b1, 1'b0, 1'b0);
        cycle();
        cycle();
        imGnt      = 1'b0;
        redirect   = 1'b1;
        redirectPc = 16'h0100;
        @(negedge clk);
        check("t3_imReq_redir", imReq, 0);
        cycle();
        redirect = 1'b0;
        drive(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("t3_fetchPc", fetchPc, 16'h0100);
        waited = 0;
        while (!dValid && waited < 20) begin
            cycle();
            @(negedge clk);
            waited++;
        end
        check("t3_dv_seen", dValid, 1);
        check("t3_dPc", dPc, 16'h0100);
        check("t3_dInstr", dInstr, 16'h5A5B);
        repeat (6) cycle();

        // 4: halt with two filled and one outstanding
        do_reset();
        lat = 1;
        drive(1'b1, 1'b0, 1'b0);
        repeat (3) cycle();
        hlt = 1'b1;
        g0  = n_gnt;
        repeat (4) cycle();
        @(negedge clk);
        check("t4_no_grant", n_gnt - g0, 0);
        check("t4_fetchPc_hold", fetchPc, 3);
        g0 = n_pop;
        dReady = 1'b1;
        repeat (6) cycle();
        @(negedge clk);
        check("t4_delivered3", n_pop - g0, 3);
        check("t4_fetchPc_end", fetchPc, 3);
        check("t4_dv_empty", dValid, 0);
        hlt = 1'b0;
        repeat (4) cycle();

        // 6: asynchronous reset mid-stream
        do_reset();
        lat = 1;
        drive(1'b1, 1'b1, 1'b0);
        repeat (6) cycle();
        @(negedge clk);
        check("t6_dv_before", dValid, 1);
        #2;
        nRst = 1'b0;
        #1;
        check("t6_dv_rst", dValid, 0);
        check("t6_fetchPc_rst", fetchPc, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        nRst = 1'b1;
        cycle();
        cycle();
        @(negedge clk);
        check("t6_restart_dv", dValid, 1);
        check("t6_restart_dPc", dPc, 0);
        repeat (8) cycle();

        // 5: reset PC near wrap (second instance)
        check("t5_pops", n2, 4);
        for (int i = 0; i < 4; i++) check("t5_dPc", pc2_got[i], pc2_want[i]);
        check("t5_dInstr0", instr2_first, 16'hA4A5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
